// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg: shared types and sizes for the instruction boot path      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int INST_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_INST = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_WR      = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  // Byte idx of a word, counted from the most significant end.
  function automatic logic [BYTE_W-1:0] msb_byte(input logic [INST_W-1:0] word,
                                                 input logic [1:0]        idx);
    return BYTE_W'(word >> (BYTE_W * (BYTES_PER_INST - 1 - int'(idx))));
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_serializer.sv
// +--------------------------------------------------------------------+
// | byte_serializer: latches a word and emits it MSB-first, one byte   |
// | per cycle, with a pulse on the final byte.  Rev 1.0                |
// +--------------------------------------------------------------------+
`default_nettype none

module byte_serializer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] word,
  output logic              busy,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last_byte
);

  logic [INST_W-1:0] r_word;
  logic [1:0]        r_idx;
  logic              r_busy;
  logic [BYTE_W-1:0] r_byte;

  // The byte register is loaded together with the word so the first byte
  // is already on the output in the cycle after the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= 2'd0;
      r_busy <= 1'b0;
      r_byte <= '0;
    end else if (load) begin
      r_word <= word;
      r_idx  <= 2'd0;
      r_busy <= 1'b1;
      r_byte <= msb_byte(word, 2'd0);
    end else if (r_busy) begin
      if (r_idx == 2'd3) begin
        r_busy <= 1'b0;
      end else begin
        r_idx  <= r_idx + 2'd1;
        r_byte <= msb_byte(r_word, r_idx + 2'd1);
      end
    end
  end

  assign busy      = r_busy;
  assign byte_out  = r_byte;
  assign last_byte = r_busy && (r_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// +--------------------------------------------------------------------+
// | imem_boot_loader: streams 32-bit words big-endian into a byte-wide |
// | instruction memory, then initialises PC and releases the CPU.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module imem_boot_loader
  import cpu_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_word,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [BYTE_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              pc_init_we,
  output logic [INST_W-1:0] pc_init,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-2:0] word_count
);

  // Pointer carries one extra bit so it can sit at 2^ADDR_W after a word
  // that ends on the last byte without wrapping back to a legal address.
  localparam int                PTR_W     = ADDR_W + 1;
  localparam logic [PTR_W-1:0]  BASE_PTR  = PTR_W'(BASE_ADDR);
  localparam logic [PTR_W-1:0]  LAST_ADDR = PTR_W'((2 ** ADDR_W) - 1);

  state_t              r_state, w_state_nxt;
  logic [PTR_W-1:0]    r_ptr;
  logic [ADDR_W-2:0]   r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_err;
  logic                r_last;

  logic                w_xfer, w_overflow, w_accept, w_trap, w_start_ok;
  logic                w_ser_busy, w_ser_last;
  logic [BYTE_W-1:0]   w_ser_byte;

  assign w_xfer     = (r_state == ST_RECV) && in_valid;
  assign w_overflow = (r_ptr + PTR_W'(BYTES_PER_INST - 1)) > LAST_ADDR;
  assign w_accept   = w_xfer && !w_overflow;
  assign w_trap     = w_xfer && w_overflow;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERROR));

  byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (w_accept),
    .word      (in_word),
    .busy      (w_ser_busy),
    .byte_out  (w_ser_byte),
    .last_byte (w_ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    cpu_hold    = 1'b1;
    pc_init_we  = 1'b0;
    load_done   = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERROR: begin
        if (start) w_state_nxt = ST_RECV;
      end
      ST_RECV: begin
        in_ready = 1'b1;
        if (w_xfer) w_state_nxt = w_overflow ? ST_ERROR : ST_WR;
      end
      ST_WR: begin
        if (w_ser_last) w_state_nxt = r_last ? ST_RELEASE : ST_RECV;
      end
      ST_RELEASE: begin
        pc_init_we  = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) w_state_nxt = ST_RECV;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= BASE_PTR;
      r_count <= '0;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_ptr   <= BASE_PTR;
        r_count <= '0;
        r_err   <= 1'b0;
      end
      if (w_accept) begin
        r_last <= in_last;
        r_addr <= r_ptr[ADDR_W-1:0];
      end
      if (w_trap) r_err <= 1'b1;
      if (w_ser_busy && !w_ser_last) r_addr <= r_addr + ADDR_W'(1);
      if (w_ser_last) begin
        r_ptr   <= r_ptr + PTR_W'(BYTES_PER_INST);
        r_count <= r_count + (ADDR_W-1)'(1);
      end
    end
  end

  assign imem_we    = w_ser_busy;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_ser_byte;
  assign pc_init    = INST_W'(BASE_ADDR);
  assign load_err   = r_err;
  assign word_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// +--------------------------------------------------------------------+
// | tb_imem_boot_loader: directed + random bench for the boot loader   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_imem_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default geometry
  logic        a_rst, a_start, a_in_valid, a_in_last;
  logic [31:0] a_in_word;
  logic        a_in_ready, a_imem_we, a_cpu_hold, a_pc_init_we, a_load_done, a_load_err;
  logic [9:0]  a_imem_addr;
  logic [7:0]  a_imem_wdata;
  logic [31:0] a_pc_init;
  logic [8:0]  a_word_count;

  // DUT B: 16-byte memory based at 8
  logic        b_rst, b_start, b_in_valid, b_in_last;
  logic [31:0] b_in_word;
  logic        b_in_ready, b_imem_we, b_cpu_hold, b_pc_init_we, b_load_done, b_load_err;
  logic [3:0]  b_imem_addr;
  logic [7:0]  b_imem_wdata;
  logic [31:0] b_pc_init;
  logic [2:0]  b_word_count;

  imem_boot_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .in_valid(a_in_valid),
    .in_word(a_in_word), .in_last(a_in_last), .in_ready(a_in_ready),
    .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .cpu_hold(a_cpu_hold), .pc_init_we(a_pc_init_we), .pc_init(a_pc_init),
    .load_done(a_load_done), .load_err(a_load_err), .word_count(a_word_count));

  imem_boot_loader #(.ADDR_W(4), .BASE_ADDR(8)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .in_valid(b_in_valid),
    .in_word(b_in_word), .in_last(b_in_last), .in_ready(b_in_ready),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .cpu_hold(b_cpu_hold), .pc_init_we(b_pc_init_we), .pc_init(b_pc_init),
    .load_done(b_load_done), .load_err(b_load_err), .word_count(b_word_count));

  // Instruction memories and event counters fed by the DUT write ports
  logic [7:0]  mem_a [0:1023];
  logic [7:0]  mem_b [0:15];
  bit          mon_en = 1'b0;
  int          we_cnt_a = 0, pc_cnt_a = 0, we_cnt_b = 0, pc_cnt_b = 0;
  logic [31:0] last_pc_a = '0, last_pc_b = '0;

  always @(posedge clk) begin
    if (mon_en) begin
      if (a_imem_we) begin mem_a[a_imem_addr] <= a_imem_wdata; we_cnt_a <= we_cnt_a + 1; end
      if (a_pc_init_we) begin pc_cnt_a <= pc_cnt_a + 1; last_pc_a <= a_pc_init; end
      if (b_imem_we) begin mem_b[b_imem_addr] <= b_imem_wdata; we_cnt_b <= we_cnt_b + 1; end
      if (b_pc_init_we) begin pc_cnt_b <= pc_cnt_b + 1; last_pc_b <= b_pc_init; end
    end
  end

  // Reference model: expected memory image
  logic [7:0] ref_a [0:1023];
  logic [7:0] ref_b [0:15];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return 8'((w >> (8 * (3 - i))) & 32'hFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_start_hold", a_cpu_hold, 1);
    check("a_start_done", a_load_done, 0);
    check("a_start_ready", a_in_ready, 1);
    check("a_start_count", a_word_count, 0);
    check("a_start_err", a_load_err, 0);
  endtask

  // Hand one word over, then check every byte write cycle and what follows.
  task automatic send_a(input logic [31:0] w, input logic last, input int ptr,
                        input bit poke_start, input bit rst_mid);
    int n = 0;
    a_in_valid = 1'b1; a_in_word = w; a_in_last = last;
    while (!a_in_ready && n < 20) begin @(negedge clk); n++; end
    check("a_ready_wait", n < 20, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      a_start = (poke_start && b == 1);
      check($sformatf("a_we[%0d]", ptr + b), a_imem_we, 1);
      check($sformatf("a_addr[%0d]", ptr + b), a_imem_addr, ptr + b);
      check($sformatf("a_data[%0d]", ptr + b), a_imem_wdata, byte_of(w, b));
      check("a_wr_ready", a_in_ready, 0);
      ref_a[ptr + b] = byte_of(w, b);
      if (rst_mid && b == 2) begin a_rst = 1'b1; break; end
    end
    if (!rst_mid) begin
      @(negedge clk);
      a_start = 1'b0;
      if (!last) begin
        check("a_next_ready", a_in_ready, 1);
      end else begin
        check("a_release_pc", a_pc_init_we, 1);
        check("a_release_hold", a_cpu_hold, 1);
        @(negedge clk);
        check("a_done", a_load_done, 1);
        check("a_done_hold", a_cpu_hold, 0);
      end
    end
  endtask

  task automatic send_b(input logic [31:0] w, input logic last, input int ptr);
    int n = 0;
    b_in_valid = 1'b1; b_in_word = w; b_in_last = last;
    while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
    check("b_ready_wait", n < 20, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
    for (int b = 0; b < 4; b++) ref_b[ptr + b] = byte_of(w, b);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] boot [5];
    logic [31:0] bp [6];
    logic [31:0] rw [4];
    int idx, cycles, ready_cnt, we_snap;

    boot = '{32'h8C410021, 32'h8C430021, 32'h00011020, 32'h00421020, 32'h00421020};
    for (int i = 0; i < 6; i++) bp[i] = $urandom;
    for (int i = 0; i < 4; i++) rw[i] = $urandom;

    a_rst = 1'b1; a_start = 1'b0; a_in_valid = 1'b0; a_in_word = '0; a_in_last = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_in_valid = 1'b0; b_in_word = '0; b_in_last = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; mon_en = 1'b1;

    check("rst_in_ready", a_in_ready, 0);
    check("rst_imem_we", a_imem_we, 0);
    check("rst_imem_addr", a_imem_addr, 0);
    check("rst_imem_wdata", a_imem_wdata, 0);
    check("rst_cpu_hold", a_cpu_hold, 1);
    check("rst_pc_init_we", a_pc_init_we, 0);
    check("rst_pc_init", a_pc_init, 0);
    check("rst_load_done", a_load_done, 0);
    check("rst_load_err", a_load_err, 0);
    check("rst_word_count", a_word_count, 0);
    check("rst_b_imem_addr", b_imem_addr, 8);
    check("rst_b_pc_init", b_pc_init, 8);

    // Boot a 5-word program
    start_a();
    for (int k = 0; k < 5; k++) send_a(boot[k], k == 4, 4 * k, 1'b0, 1'b0);
    check("boot_count", a_word_count, 5);
    check("boot_pc_pulses", pc_cnt_a, 1);
    check("boot_pc_value", last_pc_a, 0);
    check("boot_byte0", mem_a[0], 8'h8C);
    check("boot_byte13", mem_a[13], 8'h42);
    for (int i = 0; i < 20; i++) check($sformatf("boot_mem[%0d]", i), mem_a[i], ref_a[i]);

    // Reload from DONE
    start_a();
    send_a(32'hFFFFFFFF, 1'b1, 0, 1'b0, 1'b0);
    check("reload_pc_pulses", pc_cnt_a, 2);
    check("reload_count", a_word_count, 1);
    for (int i = 0; i < 4; i++) check($sformatf("reload_mem[%0d]", i), mem_a[i], 8'hFF);

    // Backpressure: valid held high the whole time
    start_a();
    we_snap = we_cnt_a;
    idx = 0; cycles = 0; ready_cnt = 0;
    a_in_valid = 1'b1; a_in_word = bp[0]; a_in_last = 1'b0;
    while (idx < 6 && cycles < 100) begin
      cycles++;
      if (a_in_ready) begin
        for (int b = 0; b < 4; b++) ref_a[4 * idx + b] = byte_of(bp[idx], b);
        ready_cnt++; idx++;
        @(posedge clk); #1;
        if (idx < 6) begin a_in_word = bp[idx]; a_in_last = (idx == 5); end
        else begin a_in_valid = 1'b0; a_in_last = 1'b0; end
      end
      @(negedge clk);
    end
    check("bp_ready_cnt", ready_cnt, 6);
    check("bp_cycles", cycles, 26);
    cycles = 0;
    while (!a_load_done && cycles < 20) begin @(negedge clk); cycles++; end
    check("bp_done", a_load_done, 1);
    check("bp_we_cycles", we_cnt_a - we_snap, 24);
    check("bp_count", a_word_count, 6);
    for (int i = 0; i < 24; i++) check($sformatf("bp_mem[%0d]", i), mem_a[i], ref_a[i]);

    // start ignored while in WR and RECV
    start_a();
    send_a(rw[0], 1'b0, 0, 1'b1, 1'b0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("ign_count", a_word_count, 1);
    check("ign_ready", a_in_ready, 1);
    send_a(rw[1], 1'b1, 4, 1'b0, 1'b0);
    check("ign_final_count", a_word_count, 2);
    for (int i = 0; i < 8; i++) check($sformatf("ign_mem[%0d]", i), mem_a[i], ref_a[i]);

    // Reset during WR b=2 of word 1
    start_a();
    send_a(rw[2], 1'b0, 0, 1'b0, 1'b0);
    send_a(rw[3], 1'b0, 4, 1'b0, 1'b1);
    @(negedge clk);
    check("rmid_we", a_imem_we, 0);
    check("rmid_hold", a_cpu_hold, 1);
    check("rmid_count", a_word_count, 0);
    check("rmid_ready", a_in_ready, 0);
    check("rmid_addr", a_imem_addr, 0);
    we_snap = we_cnt_a;
    a_start = 1'b1;
    @(negedge clk);
    check("rst_over_start", a_in_ready, 0);
    a_rst = 1'b0; a_start = 1'b0;
    repeat (4) @(negedge clk);
    check("rmid_no_writes", we_cnt_a, we_snap);
    check("rmid_idle", a_in_ready, 0);
    check("rmid_mem4", mem_a[4], byte_of(rw[3], 0));
    check("rmid_mem5", mem_a[5], byte_of(rw[3], 1));
    check("rmid_mem7", mem_a[7], ref_a[7]);

    // Overflow trap on the small memory
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    send_b(rw[0], 1'b0, 8);
    send_b(rw[1], 1'b0, 12);
    @(negedge clk);
    check("ovf_count2", b_word_count, 2);
    check("ovf_addr15", b_imem_addr, 15);
    for (int i = 8; i < 16; i++) check($sformatf("ovf_mem[%0d]", i), mem_b[i], ref_b[i]);
    b_in_valid = 1'b1; b_in_word = rw[2]; b_in_last = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_last = 1'b0;
    @(negedge clk);
    check("ovf_err", b_load_err, 1);
    check("ovf_ready", b_in_ready, 0);
    check("ovf_hold", b_cpu_hold, 1);
    check("ovf_we", b_imem_we, 0);
    repeat (5) @(negedge clk);
    check("ovf_we_total", we_cnt_b, 8);
    check("ovf_no_pc", pc_cnt_b, 0);
    check("ovf_err_sticky", b_load_err, 1);
    check("ovf_hold_sticky", b_cpu_hold, 1);
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    check("ovf_recover_err", b_load_err, 0);
    check("ovf_recover_ready", b_in_ready, 1);
    check("ovf_recover_count", b_word_count, 0);
    send_b(rw[3], 1'b1, 8);
    repeat (2) @(negedge clk);
    check("ovf_recover_done", b_load_done, 1);
    check("ovf_recover_pc", last_pc_b, 8);
    check("ovf_recover_pulses", pc_cnt_b, 1);
    for (int i = 8; i < 12; i++) check($sformatf("ovf2_mem[%0d]", i), mem_b[i], ref_b[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
